// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns the scan-code-set-2 byte stream from ps2_rx into
// per-player game commands for the controller. It tracks the E0/F0 prefixes
// and which keys are held, and emits a 1-cycle strobe carrying the direction
// and the bomb flag.
// Optional feature macro: KEYDEC_REPEAT_EN. When it is defined, a held
// direction is re-strobed every REPEAT_TICKS cycles. When it is undefined,
// strobes occur only on make events and REPEAT_TICKS is unused.

module ps2_key_player #(
  parameter int REPEAT_TICKS = 12_500_000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir_make,
  input  logic       dir_break,
  input  logic [1:0] dir_idx,
  input  logic       bomb_make,
  input  logic       bomb_break,
  output logic [2:0] direction,
  output logic       bomb,
  output logic       out_valid
);

  // Direction codes: 0 none, 1 up, 2 down, 3 left, 4 right.
  // Held-mask bit i corresponds to direction code i+1.
  function automatic logic [2:0] prio_dir(input logic [3:0] mask);
    logic [2:0] d;
    if (mask[0]) begin
      d = 3'd1;
    end else if (mask[1]) begin
      d = 3'd2;
    end else if (mask[2]) begin
      d = 3'd3;
    end else if (mask[3]) begin
      d = 3'd4;
    end else begin
      d = 3'd0;
    end
    return d;
  endfunction

  logic [3:0] held_r, held_n_s;
  logic       bomb_held_r, bomb_held_n_s;
  logic [2:0] dir_r, dir_n_s;
  logic       valid_r, bomb_r;
  logic       key_valid_s, key_bomb_s, reload_s;
  logic       rpt_valid_s;
  logic [2:0] key_dir_s;

  assign key_dir_s = {1'b0, dir_idx} + 3'd1;

  // Key-event handling: held masks, current direction and the key strobe.
  always_comb begin
    held_n_s      = held_r;
    bomb_held_n_s = bomb_held_r;
    dir_n_s       = dir_r;
    key_valid_s   = 1'b0;
    key_bomb_s    = 1'b0;
    reload_s      = 1'b0;
    if (dir_make && !held_r[dir_idx]) begin
      held_n_s[dir_idx] = 1'b1;
      dir_n_s           = key_dir_s;
      key_valid_s       = 1'b1;
      reload_s          = 1'b1;
    end else if (dir_break) begin
      held_n_s[dir_idx] = 1'b0;
      // Only releasing the active key changes the direction; fall back to
      // whatever is still held, in up > down > left > right order.
      if (dir_r == key_dir_s) begin
        dir_n_s = prio_dir(held_n_s);
      end else begin
        dir_n_s = dir_r;
      end
    end else if (bomb_make && !bomb_held_r) begin
      bomb_held_n_s = 1'b1;
      key_valid_s   = 1'b1;
      key_bomb_s    = 1'b1;
    end else if (bomb_break) begin
      bomb_held_n_s = 1'b0;
    end else begin
      // Typematic repeats of held keys and idle cycles leave state alone.
      held_n_s = held_r;
    end
  end

`ifdef KEYDEC_REPEAT_EN
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic             expire_s;

  // Repeat countdown: runs only while a direction is active; a key strobe
  // or an expiry reloads it, and losing the direction clears it.
  always_comb begin
    expire_s = (dir_r != 3'd0) && (cnt_r == CNT_ZERO);
    if (dir_n_s == 3'd0) begin
      cnt_n_s = CNT_ZERO;
    end else if (reload_s || expire_s) begin
      cnt_n_s = RELOAD;
    end else begin
      cnt_n_s = cnt_r - CNT_ONE;
    end
    // An expiry is suppressed when the direction is released that cycle.
    if (expire_s && (dir_n_s != 3'd0)) begin
      rpt_valid_s = 1'b1;
    end else begin
      rpt_valid_s = 1'b0;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_n_s;
    end
  end
`else
  assign rpt_valid_s = 1'b0;
`endif

  // Player state and registered command outputs; a key event takes priority
  // over a coincident repeat expiry, so at most one strobe is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r      <= 4'd0;
      bomb_held_r <= 1'b0;
      dir_r       <= 3'd0;
      valid_r     <= 1'b0;
      bomb_r      <= 1'b0;
    end else begin
      held_r      <= held_n_s;
      bomb_held_r <= bomb_held_n_s;
      dir_r       <= dir_n_s;
      valid_r     <= key_valid_s | rpt_valid_s;
      bomb_r      <= key_valid_s & key_bomb_s;
    end
  end

  assign direction = dir_r;
  assign bomb      = bomb_r;
  assign out_valid = valid_r;

endmodule

module ps2_key_decoder #(
  parameter int REPEAT_TICKS = 12_500_000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic [2:0] direction_1,
  output logic [2:0] direction_2,
  output logic       bomb_1,
  output logic       bomb_2,
  output logic       out_valid_1,
  output logic       out_valid_2
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } pfx_state_t;

  pfx_state_t state_r, state_n_s;
  logic       make_s, brk_s, ext_s;

  // Prefix state register; a reset drops any partially received prefix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Prefix FSM: classifies each byte as make/break with its extended flag.
  always_comb begin
    state_n_s = state_r;
    make_s    = 1'b0;
    brk_s     = 1'b0;
    ext_s     = 1'b0;
    if (rx_done_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_n_s = ST_E0;
          end else if (rx_data == 8'hF0) begin
            state_n_s = ST_F0;
          end else begin
            make_s    = 1'b1;
            state_n_s = ST_IDLE;
          end
        end
        ST_E0: begin
          if (rx_data == 8'hF0) begin
            state_n_s = ST_E0F0;
          end else begin
            make_s    = 1'b1;
            ext_s     = 1'b1;
            state_n_s = ST_IDLE;
          end
        end
        ST_F0: begin
          brk_s     = 1'b1;
          state_n_s = ST_IDLE;
        end
        ST_E0F0: begin
          brk_s     = 1'b1;
          ext_s     = 1'b1;
          state_n_s = ST_IDLE;
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  logic       p1_dir_hit_s, p1_bomb_hit_s, p2_dir_hit_s, p2_bomb_hit_s;
  logic [1:0] p1_idx_s, p2_idx_s;

  // Key map; E1 and every code not listed (including E0 5A) map to nothing.
  always_comb begin
    p1_dir_hit_s  = 1'b0;
    p1_bomb_hit_s = 1'b0;
    p2_dir_hit_s  = 1'b0;
    p2_bomb_hit_s = 1'b0;
    p1_idx_s      = 2'd0;
    p2_idx_s      = 2'd0;
    case ({ext_s, rx_data})
      9'h01D: begin p1_dir_hit_s = 1'b1; p1_idx_s = 2'd0; end
      9'h01B: begin p1_dir_hit_s = 1'b1; p1_idx_s = 2'd1; end
      9'h01C: begin p1_dir_hit_s = 1'b1; p1_idx_s = 2'd2; end
      9'h023: begin p1_dir_hit_s = 1'b1; p1_idx_s = 2'd3; end
      9'h029: begin p1_bomb_hit_s = 1'b1; end
      9'h05A: begin p2_bomb_hit_s = 1'b1; end
      9'h175: begin p2_dir_hit_s = 1'b1; p2_idx_s = 2'd0; end
      9'h172: begin p2_dir_hit_s = 1'b1; p2_idx_s = 2'd1; end
      9'h16B: begin p2_dir_hit_s = 1'b1; p2_idx_s = 2'd2; end
      9'h174: begin p2_dir_hit_s = 1'b1; p2_idx_s = 2'd3; end
      default: begin
        p1_dir_hit_s = 1'b0;
      end
    endcase
  end

  ps2_key_player #(
    .REPEAT_TICKS (REPEAT_TICKS),
    .CNT_W        (CNT_W)
  ) u_player_1 (
    .clk        (clk),
    .rst        (rst),
    .dir_make   (make_s & p1_dir_hit_s),
    .dir_break  (brk_s & p1_dir_hit_s),
    .dir_idx    (p1_idx_s),
    .bomb_make  (make_s & p1_bomb_hit_s),
    .bomb_break (brk_s & p1_bomb_hit_s),
    .direction  (direction_1),
    .bomb       (bomb_1),
    .out_valid  (out_valid_1)
  );

  ps2_key_player #(
    .REPEAT_TICKS (REPEAT_TICKS),
    .CNT_W        (CNT_W)
  ) u_player_2 (
    .clk        (clk),
    .rst        (rst),
    .dir_make   (make_s & p2_dir_hit_s),
    .dir_break  (brk_s & p2_dir_hit_s),
    .dir_idx    (p2_idx_s),
    .bomb_make  (make_s & p2_bomb_hit_s),
    .bomb_break (brk_s & p2_bomb_hit_s),
    .direction  (direction_2),
    .bomb       (bomb_2),
    .out_valid  (out_valid_2)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected strobes are queued per
// player with the cycle they must appear in; a monitor pops and compares.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic [2:0] direction_1, direction_2;
  logic       bomb_1, bomb_2, out_valid_1, out_valid_2;

  typedef struct packed {
    int         cyc;
    logic [2:0] dir;
    logic       bomb;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  ps2_key_decoder #(
    .REPEAT_TICKS (8),
    .CNT_W        (24)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .direction_1  (direction_1),
    .direction_2  (direction_2),
    .bomb_1       (bomb_1),
    .bomb_2       (bomb_2),
    .out_valid_1  (out_valid_1),
    .out_valid_2  (out_valid_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare one observed strobe against the head of a player's queue.
  task automatic score(input int pl, input logic [2:0] d, input logic bm);
    exp_t e;
    n_checks++;
    if ((pl == 1 && q1.size() == 0) || (pl == 2 && q2.size() == 0)) begin
      n_fail++;
      $display("FAIL p%0d_unexpected_strobe: cycle %0d dir %0d bomb %0d, none expected", pl, cyc, d, bm);
    end else begin
      if (pl == 1) e = q1.pop_front(); else e = q2.pop_front();
      if (e.cyc != cyc || e.dir != d || e.bomb != bm) begin
        n_fail++;
        $display("FAIL p%0d_strobe: got cycle %0d dir %0d bomb %0d, expected cycle %0d dir %0d bomb %0d",
                 pl, cyc, d, bm, e.cyc, e.dir, e.bomb);
      end
    end
  endtask

  task automatic run_monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid_1) score(1, direction_1, bomb_1);
        if (out_valid_2) score(2, direction_2, bomb_2);
      end
    end
  endtask

  // Drives one byte for one cycle; call at a negedge, returns at the next.
  task automatic send(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
  endtask

  task automatic send_exp(input logic [7:0] b, input int pl, input logic [2:0] d, input logic bm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.dir  = d;
    e.bomb = bm;
    if (pl == 1) q1.push_back(e); else q2.push_back(e);
    send(b);
  endtask

  initial begin
    int   k;
    exp_t e;
    cyc          = 0;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    fork
      run_monitor();
    join_none

    // 1. reset state, then a P1 up make
    repeat (2) @(negedge clk);
    check("rst_direction_1", direction_1, 0);
    check("rst_direction_2", direction_2, 0);
    check("rst_bomb_1", bomb_1, 0);
    check("rst_bomb_2", bomb_2, 0);
    check("rst_out_valid_1", out_valid_1, 0);
    check("rst_out_valid_2", out_valid_2, 0);
    rst = 1'b0;
    @(negedge clk);
    send_exp(8'h1D, 1, 3'd1, 1'b0);
    check("t1_direction_1", direction_1, 1);
    check("t1_direction_2", direction_2, 0);
    send(8'hF0); send(8'h1D);
    check("t1_release", direction_1, 0);

    // 2. P2 right make, extended break, then a bare 74 (unmapped)
    send(8'hE0); send_exp(8'h74, 2, 3'd4, 1'b0);
    check("t2_direction_2_right", direction_2, 4);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("t2_direction_2_break", direction_2, 0);
    send(8'h74);
    @(negedge clk);
    check("t2_bare_74_dir1", direction_1, 0);
    check("t2_bare_74_dir2", direction_2, 0);

    // 3. priority fallback and breaking a non-current held key
    send_exp(8'h1D, 1, 3'd1, 1'b0);
    send_exp(8'h23, 1, 3'd4, 1'b0);
    send(8'hF0); send(8'h23);
    check("t3_fallback_up", direction_1, 1);
    send_exp(8'h23, 1, 3'd4, 1'b0);
    send(8'hF0); send(8'h1D);
    check("t3_break_noncurrent", direction_1, 4);
    send(8'hF0); send(8'h23);
    check("t3_all_released", direction_1, 0);

    // 4. bomb keeps the held direction, then bomb typematic
    send_exp(8'h1D, 1, 3'd1, 1'b0);
    send_exp(8'h29, 1, 3'd1, 1'b1);
    send(8'hF0); send(8'h29);
    send(8'hF0); send(8'h1D);
    send_exp(8'h29, 1, 3'd0, 1'b1);
    send(8'h29); send(8'h29);
    send(8'hF0); send(8'h29);
    send_exp(8'h29, 1, 3'd0, 1'b1);
    send(8'hF0); send(8'h29);
    check("t4_direction_1_unchanged", direction_1, 0);

    // 5. held left: repeats at +9 and +17 only when the feature is built in
    k = cyc;
    send_exp(8'h1C, 1, 3'd3, 1'b0);
`ifdef KEYDEC_REPEAT_EN
    e.cyc = k + 9;  e.dir = 3'd3; e.bomb = 1'b0; q1.push_back(e);
    e.cyc = k + 17; q1.push_back(e);
`endif
    repeat (17) @(negedge clk);
    check("t5_held_left", direction_1, 3);
    send(8'hF0); send(8'h1C);
    check("t5_released", direction_1, 0);
    repeat (10) @(negedge clk);

    // 6. reset discards a pending E0; back-to-back P1/P2 makes
    send(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h75);
    @(negedge clk);
    check("t6_e0_discarded", direction_2, 0);
    send_exp(8'h1B, 1, 3'd2, 1'b0);
    send_exp(8'h5A, 2, 3'd0, 1'b1);
    check("t6_direction_1_down", direction_1, 2);
    send(8'hF0); send(8'h1B);
    send(8'hF0); send(8'h5A);
    repeat (12) @(negedge clk);

    check("p1_pending_strobes", q1.size(), 0);
    check("p2_pending_strobes", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
